signed_seg_display: RTL

//  Downstream consumer of the 8-bit two's-complement negation/ALU result. Captures a

---
 rtl/signed_seg_display.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/signed_seg_display.sv
// signed_seg_display: captures a signed byte and converts its magnitude to three
// BCD digits by sequential double-dabble. Drives a 4-digit multiplexed
// common-anode 7-segment display showing "[-]HTO" with leading zeros blanked.
module signed_seg_display #(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t                  state;
    logic [7:0]              mag;
    logic [11:0]             bcd;
    logic [2:0]              iter;
    logic                    neg;
    logic [3:0]              dig_h;
    logic [3:0]              dig_t;
    logic [3:0]              dig_o;
    logic                    neg_disp;
    logic [11:0]             bcd_adj;
    logic [11:0]             bcd_next;
    logic [7:0]              mag_next;
    logic [REFRESH_BITS+1:0] scan_cnt;
    logic [1:0]              sel;
    logic [6:0]              seg_next;

    // Segment pattern for one decimal digit, gfedcba, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step: add 3 to any nibble >= 5, then shift {bcd,mag} left.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_next, mag_next} = {bcd_adj[10:0], mag, 1'b0};
    end

    // Conversion FSM: capture on load, eight shift cycles, then commit digits atomically.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            mag      <= '0;
            bcd      <= '0;
            iter     <= '0;
            neg      <= 1'b0;
            dig_h    <= '0;
            dig_t    <= '0;
            dig_o    <= '0;
            neg_disp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        neg   <= value[7];
                        mag   <= value[7] ? (~value + 8'd1) : value;
                        bcd   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_next;
                    mag  <= mag_next;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        dig_h    <= bcd_next[11:8];
                        dig_t    <= bcd_next[7:4];
                        dig_o    <= bcd_next[3:0];
                        neg_disp <= neg;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running refresh counter; its top two bits select the active digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign sel = scan_cnt[REFRESH_BITS+1:REFRESH_BITS];

    // Pick the segment pattern for the selected digit, applying leading-zero blanking.
    always_comb begin
        seg_next = SEG_BLANK;
        case (sel)
            2'd0: seg_next = seg7(dig_o);
            2'd1: seg_next = (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg7(dig_t);
            2'd2: seg_next = (dig_h == 4'd0) ? SEG_BLANK : seg7(dig_h);
            2'd3: seg_next = neg_disp ? SEG_DASH : SEG_BLANK;
            default: seg_next = SEG_BLANK;
        endcase
    end

    // Register pin outputs so cathodes and anodes switch together, glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else begin
            seg <= seg_next;
            an  <= ~(4'b0001 << sel);
        end
    end

    assign dp = 1'b1;

endmodule
